// File: rtl/ema_seq_alu.sv
// Sequential ADD / radix-2 shift-add MULT responder for the EMA filter datapath.
// One job at a time; the result is registered and announced by a one-cycle valid_o pulse.
module ema_seq_alu #(
    parameter int Win  = 8,
    parameter int Wout = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [Win-1:0]       op1_i,
    input  logic [Win:0]         op2_i,
    input  logic                 valid_i,
    input  logic [1:0]           mode_i,
    output logic [Win+Wout-1:0]  res_o,
    output logic                 valid_o,
    output logic                 busy_o
);

    localparam int RW = Win + Wout;
    localparam int AW = (2 * Win + 1 > RW) ? 2 * Win + 1 : RW;
    localparam int CW = $clog2(Win + 1);

    localparam logic [1:0] MODE_ADD  = 2'd1;
    localparam logic [1:0] MODE_MULT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD_EXEC,
        S_MUL_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [Win-1:0]  opa_q, opa_d;
    logic [Win:0]    opb_q, opb_d;
    logic [1:0]      mode_q, mode_d;
    logic [AW-1:0]   mcand_q, mcand_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   res_q, res_d;

    logic            free;
    logic            accept;
    logic            last_iter;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   acc_sum;
    logic [RW-1:0]   add_sum;

    // Handshake: a request is taken when valid_i=1 with mode ADD/MULT while the
    // block is IDLE or DONE (busy_o=0); anything else on the request channel is dropped.
    assign free   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept = free && valid_i && ((mode_i == MODE_ADD) || (mode_i == MODE_MULT));

    assign add_sum = {{(RW - Win){opa_q[Win-1]}}, opa_q}
                   + {{(RW - Win - 1){opb_q[Win]}}, opb_q};

    // The multiplier bit currently examined is always opb_q[0]; the top bit carries negative weight.
    assign last_iter = (cnt_q == CW'(Win));
    assign addend    = opb_q[0] ? mcand_q : '0;
    assign acc_sum   = last_iter ? (acc_q - addend) : (acc_q + addend);

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        mode_d  = mode_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    opa_d   = op1_i;
                    opb_d   = op2_i;
                    mode_d  = mode_i;
                    mcand_d = {{(AW - Win){op1_i[Win-1]}}, op1_i};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (mode_i == MODE_ADD) ? S_ADD_EXEC : S_MUL_RUN;
                end
            end
            S_ADD_EXEC: begin
                res_d   = add_sum;
                state_d = S_DONE;
            end
            S_MUL_RUN: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (last_iter) begin
                    res_d   = acc_sum[RW-1:0];
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            mode_q  <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            mode_q  <= mode_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign res_o   = res_q;
    assign valid_o = (state_q == S_DONE);
    assign busy_o  = (state_q == S_ADD_EXEC) || (state_q == S_MUL_RUN);

endmodule

// File: tb/tb_ema_seq_alu.sv
// Directed bench for ema_seq_alu: a job-level model checked every cycle,
// plus hand-computed result and latency expectations for each directed job.
module tb_ema_seq_alu;

    localparam int WIN  = 8;
    localparam int WOUT = 8;
    localparam int RW   = WIN + WOUT;

    logic             clk;
    logic             rst;
    logic [WIN-1:0]   op1_i;
    logic [WIN:0]     op2_i;
    logic             valid_i;
    logic [1:0]       mode_i;
    logic [RW-1:0]    res_o;
    logic             valid_o;
    logic             busy_o;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    ema_seq_alu #(.Win(WIN), .Wout(WOUT)) dut (
        .clk     (clk),
        .rst     (rst),
        .op1_i   (op1_i),
        .op2_i   (op2_i),
        .valid_i (valid_i),
        .mode_i  (mode_i),
        .res_o   (res_o),
        .valid_o (valid_o),
        .busy_o  (busy_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: a job costs 1 (ADD) or WIN+1 (MULT) busy cycles and then
    // presents the truncated exact sum/product for one cycle.
    int           m_busy_left = 0;
    logic [RW-1:0] m_pending  = '0;
    logic [RW-1:0] m_res      = '0;
    bit           m_valid     = 0;

    always @(posedge clk) begin : model
        int a;
        int b;
        if (rst) begin
            m_busy_left = 0;
            m_valid     = 0;
            m_res       = '0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            m_valid = (m_busy_left == 0);
            if (m_valid) m_res = m_pending;
        end else begin
            m_valid = 0;
            if (valid_i && (mode_i == 2'd1 || mode_i == 2'd2)) begin
                a = int'($signed(op1_i));
                b = int'($signed(op2_i));
                m_pending   = (mode_i == 2'd1) ? RW'(a + b) : RW'(a * b);
                m_busy_left = (mode_i == 2'd1) ? 1 : WIN + 1;
            end
        end
    end

    // scoreboard compare, every cycle, on the falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_valid", 32'(valid_o), 32'(m_valid));
            chk("cyc_busy", 32'(busy_o), 32'(m_busy_left > 0));
            chk("cyc_res", 32'(res_o), 32'(m_res));
        end
    end

    // driver tasks
    task automatic issue(input logic [1:0] mode, input logic [WIN-1:0] a, input logic [WIN:0] b);
        @(negedge clk);
        valid_i = 1'b1;
        mode_i  = mode;
        op1_i   = a;
        op2_i   = b;
        @(negedge clk);
        valid_i = 1'b0;
        mode_i  = 2'($urandom_range(0, 3));
        op1_i   = WIN'($urandom);
        op2_i   = (WIN + 1)'($urandom);
    endtask

    // Waits (bounded) for valid_o, counting busy cycles from the current cycle.
    task automatic wait_done(input string name, input logic [RW-1:0] exp_res, input int exp_busy);
        int n  = 0;
        int nb = 0;
        while (!valid_o && n < 40) begin
            if (busy_o) nb++;
            @(negedge clk);
            n++;
        end
        chk({name, "_seen"}, 32'(valid_o), 32'd1);
        chk({name, "_res"}, 32'(res_o), 32'(exp_res));
        chk({name, "_model"}, 32'(m_res), 32'(exp_res));
        chk({name, "_busy"}, 32'(nb), 32'(exp_busy));
    endtask

    task automatic job(input string name, input logic [1:0] mode, input logic [WIN-1:0] a,
                       input logic [WIN:0] b, input logic [RW-1:0] exp_res, input int exp_busy);
        issue(mode, a, b);
        wait_done(name, exp_res, exp_busy);
        @(negedge clk);
        chk({name, "_pulse_end"}, 32'(valid_o), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        mode_i  = 2'd0;
        op1_i   = '0;
        op2_i   = '0;
        @(posedge clk);
        cmp_en = 1;
        repeat (2) @(negedge clk);
        chk("rst_res", 32'(res_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;

        job("add_5_3", 2'd1, 8'd5, 9'd3, 16'h0008, 1);
        job("mul_m128_255", 2'd2, 8'h80, 9'h0FF, 16'h8080, 9);
        job("mul_127_255", 2'd2, 8'd127, 9'h0FF, 16'h7E81, 9);
        job("mul_3_m1", 2'd2, 8'd3, 9'h1FF, 16'hFFFD, 9);
        job("mul_0_aa", 2'd2, 8'd0, 9'h0AA, 16'h0000, 9);
        job("mul_m128_m256", 2'd2, 8'h80, 9'h100, 16'h8000, 9);
        job("add_m128_m256", 2'd1, 8'h80, 9'h100, 16'hFE80, 1);

        // ADD request pulsed while a MULT is running must be dropped
        issue(2'd2, 8'd127, 9'h0FF);
        repeat (2) @(negedge clk);
        valid_i = 1'b1; mode_i = 2'd1; op1_i = 8'd1; op2_i = 9'd1;
        @(negedge clk);
        valid_i = 1'b0;
        wait_done("mul_midreq", 16'h7E81, 6);
        repeat (4) @(negedge clk);
        chk("midreq_no_extra", 32'(valid_o), 32'd0);

        // IDLE and reserved modes are ignored
        @(negedge clk);
        valid_i = 1'b1; mode_i = 2'd0; op1_i = 8'd9; op2_i = 9'd9;
        @(negedge clk);
        mode_i = 2'd3;
        @(negedge clk);
        valid_i = 1'b0;
        chk("mode0_3_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        chk("mode0_3_valid", 32'(valid_o), 32'd0);
        chk("mode0_3_res", 32'(res_o), 32'h7E81);

        // back-to-back: ADD issued during the MULT's DONE cycle
        issue(2'd2, 8'd10, 9'd20);
        wait_done("b2b_mul", 16'd200, 9);
        valid_i = 1'b1; mode_i = 2'd1; op1_i = 8'd1; op2_i = 9'd1;
        @(negedge clk);
        valid_i = 1'b0;
        chk("b2b_no_bubble", 32'(busy_o), 32'd1);
        chk("b2b_gap_valid", 32'(valid_o), 32'd0);
        @(negedge clk);
        chk("b2b_add_valid", 32'(valid_o), 32'd1);
        chk("b2b_add_res", 32'(res_o), 32'd2);

        // reset during the 4th MULT iteration aborts the job
        issue(2'd2, 8'd3, 9'h1FF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_res", 32'(res_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_valid", 32'(valid_o), 32'd0);
        repeat (10) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(valid_o), 32'd0);
        end
        job("add_7_m2", 2'd1, 8'd7, 9'h1FE, 16'h0005, 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
